// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator that splits unaligned accesses into word beats on a word-organised RAM port.
module lsu_mem_initiator #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wr_mask_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d, uns_q, uns_d;
  logic [1:0]        size_q, size_d, off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        m8_q, m8_d;
  logic [63:0]       w64_q, w64_d;
  logic [31:0]       rd0_q, rd0_d, rdata_q, rdata_d;
  logic [3:0]        bmask;
  logic [7:0]        m8;
  logic              split, last, beat, b1;
  logic [63:0]       r64;
  logic [31:0]       sh, ext;
  always_comb begin
    bmask = req_size_i == 2'd0 ? 4'b0001 : req_size_i == 2'd1 ? 4'b0011 : 4'b1111;
    m8    = {4'b0000, bmask} << req_addr_i[1:0];
    split = |m8_q[7:4];
    last  = we_q || cnt_q == 3'(MEM_LATENCY);
    r64   = state_q == BEAT1 ? {mem_rdata_i, rd0_q} : {32'b0, mem_rdata_i};
    sh    = 32'(r64 >> {off_q, 3'b000});
    ext   = size_q == 2'd0 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
            size_q == 2'd1 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    off_d   = off_q;
    addr_d  = addr_q;
    m8_d    = m8_q;
    w64_d   = w64_q;
    rd0_d   = rd0_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        state_d = BEAT0;
        cnt_d   = 3'd0;
        we_d    = req_we_i;
        uns_d   = req_unsigned_i;
        size_d  = req_size_i;
        off_d   = req_addr_i[1:0];
        addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
        m8_d    = m8;
        w64_d   = req_we_i ? {32'b0, req_wdata_i} << {req_addr_i[1:0], 3'b000} : 64'b0;
      end
      BEAT0: begin
        cnt_d = last ? 3'd0 : cnt_q + 3'd1;
        if (last) begin
          state_d = split ? BEAT1 : RESP;
          rd0_d   = mem_rdata_i;
          rdata_d = split ? rdata_q : (we_q ? 32'b0 : ext);
        end
      end
      BEAT1: begin
        cnt_d = last ? 3'd0 : cnt_q + 3'd1;
        if (last) begin
          state_d = RESP;
          rdata_d = we_q ? 32'b0 : ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      m8_q    <= '0;
      w64_q   <= '0;
      rd0_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      m8_q    <= m8_d;
      w64_q   <= w64_d;
      rd0_q   <= rd0_d;
      rdata_q <= rdata_d;
    end
  end
  // RAM-side signals decode straight from state so reset silences them at once
  always_comb begin
    beat          = state_q == BEAT0 || state_q == BEAT1;
    b1            = state_q == BEAT1;
    req_ready_o   = state_q == IDLE;
    resp_valid_o  = state_q == RESP;
    resp_rdata_o  = rdata_q;
    mem_en_o      = beat;
    mem_addr_o    = beat ? (b1 ? addr_q + ADDR_W'(4) : addr_q) : '0;
    mem_wdata_o   = beat ? (b1 ? w64_q[63:32] : w64_q[31:0]) : '0;
    mem_wr_mask_o = beat && we_q ? (b1 ? m8_q[7:4] : m8_q[3:0]) : 4'b0000;
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed cycle-accurate checks of lsu_mem_initiator against a registered RAM model.
module tb_lsu_mem_initiator;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0, req_unsigned_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        resp_valid_o, mem_en_o;
  logic [31:0] resp_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
  logic [3:0]  mem_wr_mask_o;
  int          n_cmp = 0, n_bad = 0, acc = 0, acc0;

  lsu_mem_initiator #(.MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wr_mask_o(mem_wr_mask_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return a == 32'h100 ? 32'hDDCCBBAA : a == 32'h104 ? 32'h44332211 :
           a == 32'hFFFFFFFC ? 32'h87654321 : a == 32'h0 ? 32'h0FEDCBA9 : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (mem_en_o && mem_wr_mask_o == 4'b0000) mem_rdata_i <= ram_rd(mem_addr_o);
    if (req_valid_i && req_ready_o) acc <= acc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    chk("ready_before_issue", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = a; req_wdata_i = wd;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0; req_we_i = ~we; req_size_i = 2'd0; req_unsigned_i = ~uns;
    req_addr_i = 32'hDEADBEE3; req_wdata_i = 32'hFFFFFFFF;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    @(negedge clk);
    chk({tag, ".en"}, 32'(mem_en_o), 32'd1);
    chk({tag, ".addr"}, mem_addr_o, a);
    chk({tag, ".mask"}, 32'(mem_wr_mask_o), 32'(m));
    if (m != 4'b0000) chk({tag, ".wdata"}, mem_wdata_o, d);
    chk({tag, ".rv"}, 32'(resp_valid_o), 32'd0);
  endtask

  task automatic resp(input string tag, input logic [31:0] d);
    @(negedge clk);
    chk({tag, ".rv"}, 32'(resp_valid_o), 32'd1);
    chk({tag, ".rdata"}, resp_rdata_o, d);
    chk({tag, ".en"}, 32'(mem_en_o), 32'd0);
    chk({tag, ".ready"}, 32'(req_ready_o), 32'd0);
  endtask

  task automatic idle(input string tag);
    chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, ".rv"}, 32'(resp_valid_o), 32'd0);
    chk({tag, ".en"}, 32'(mem_en_o), 32'd0);
    chk({tag, ".addr"}, mem_addr_o, 32'd0);
    chk({tag, ".mask"}, 32'(mem_wr_mask_o), 32'd0);
    chk({tag, ".wdata"}, mem_wdata_o, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    idle("reset");
    chk("reset.rdata", resp_rdata_o, 32'd0);
    reset = 1'b0;

    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    beat("lw100.c1", 32'h100, 4'b0000, 32'h0);
    beat("lw100.c2", 32'h100, 4'b0000, 32'h0);
    resp("lw100", 32'hDDCCBBAA);

    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    beat("lb103.c1", 32'h100, 4'b0000, 32'h0);
    beat("lb103.c2", 32'h100, 4'b0000, 32'h0);
    resp("lb103", 32'hFFFFFFDD);

    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
    beat("lbu103.c1", 32'h100, 4'b0000, 32'h0);
    beat("lbu103.c2", 32'h100, 4'b0000, 32'h0);
    resp("lbu103", 32'h000000DD);

    issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
    beat("lh102.c1", 32'h100, 4'b0000, 32'h0);
    beat("lh102.c2", 32'h100, 4'b0000, 32'h0);
    resp("lh102", 32'hFFFFDDCC);

    issue(1'b0, 2'd1, 1'b1, 32'h101, 32'h0);
    beat("lhu101.c1", 32'h100, 4'b0000, 32'h0);
    beat("lhu101.c2", 32'h100, 4'b0000, 32'h0);
    resp("lhu101", 32'h0000CCBB);

    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    beat("lw102.c1", 32'h100, 4'b0000, 32'h0);
    beat("lw102.c2", 32'h100, 4'b0000, 32'h0);
    beat("lw102.c3", 32'h104, 4'b0000, 32'h0);
    beat("lw102.c4", 32'h104, 4'b0000, 32'h0);
    resp("lw102", 32'h2211DDCC);

    issue(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000BEEF);
    beat("sh103.c1", 32'h100, 4'b1000, 32'hEF000000);
    beat("sh103.c2", 32'h104, 4'b0001, 32'h000000BE);
    resp("sh103", 32'h0);

    issue(1'b1, 2'd2, 1'b0, 32'h104, 32'h12345678);
    beat("sw104.c1", 32'h104, 4'b1111, 32'h12345678);
    resp("sw104", 32'h0);

    issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AB);
    beat("sb101.c1", 32'h100, 4'b0010, 32'h0000AB00);
    resp("sb101", 32'h0);

    issue(1'b1, 2'd3, 1'b0, 32'h108, 32'hCAFEF00D);
    beat("sz3.c1", 32'h108, 4'b1111, 32'hCAFEF00D);
    resp("sz3", 32'h0);

    issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
    beat("lwwrap.c1", 32'hFFFFFFFC, 4'b0000, 32'h0);
    beat("lwwrap.c2", 32'hFFFFFFFC, 4'b0000, 32'h0);
    beat("lwwrap.c3", 32'h00000000, 4'b0000, 32'h0);
    beat("lwwrap.c4", 32'h00000000, 4'b0000, 32'h0);
    resp("lwwrap", 32'hCBA98765);

    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    beat("rst.c1", 32'h100, 4'b0000, 32'h0);
    beat("rst.c2", 32'h100, 4'b0000, 32'h0);
    beat("rst.c3", 32'h104, 4'b0000, 32'h0);
    reset = 1'b1;
    #1;
    idle("rst.async");
    chk("rst.async.rdata", resp_rdata_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst.noresp", 32'(resp_valid_o), 32'd0);
      chk("rst.ready", 32'(req_ready_o), 32'd1);
    end

    @(negedge clk);
    acc0 = acc;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_unsigned_i = 1'b0;
    req_addr_i = 32'h100; req_wdata_i = 32'h0;
    beat("hold.c1", 32'h100, 4'b0000, 32'h0);
    beat("hold.c2", 32'h100, 4'b0000, 32'h0);
    resp("hold", 32'hDDCCBBAA);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("hold.accepts", 32'(acc - acc0), 32'd1);
    idle("hold.after");

    issue(1'b0, 2'd1, 1'b1, 32'h101, 32'h0);
    beat("next.c1", 32'h100, 4'b0000, 32'h0);
    beat("next.c2", 32'h100, 4'b0000, 32'h0);
    resp("next", 32'h0000CCBB);
    @(negedge clk);
    idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator between the core's execute stage and the word-organised data RAM port (en / address / data_in / data_out / 4-bit byte write mask).
- Accepts one byte, half or word request at a time and drives the RAM-side signals.
- Splits any access that crosses a 32-bit word boundary into two word beats, merges read data, and returns a sign- or zero-extended result.

Parameters:
- MEM_LATENCY, 1: clock cycles from the start of a read beat to the edge at which RAM read data is sampled (range 1-7).
- ADDR_W, `API_ADDR_WIDTH (32): byte address width.
- DATA_W, `API_DATA_WIDTH (32): data width (fixed 32; lane logic assumes 4 bytes).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block idle; request accepted on posedge when req_valid_i && req_ready_o.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned_i  in  1  load: 1 = zero-extend, 0 = sign-extend.
- req_addr_i  in  ADDR_W  byte address; any alignment is allowed.
- req_wdata_i  in  DATA_W  store data, right-justified.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  DATA_W  load result; 0 for stores.
- mem_en_o  out  1  RAM chip select.
- mem_addr_o  out  ADDR_W  word-aligned byte address (bits [1:0] = 00).
- mem_wdata_o  out  DATA_W  lane-positioned write data.
- mem_wr_mask_o  out  4  byte write mask; 0000 = read.
- mem_rdata_i  in  DATA_W  RAM read data.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - req_ready_o=1; resp_valid_o=0; resp_rdata_o=0.
  - mem_en_o=0; mem_addr_o=0; mem_wdata_o=0; mem_wr_mask_o=0.
  - Any in-flight access is abandoned with no response.
- FSM states:
  - IDLE: ready=1. On accept, latch all req fields and compute lanes, then go to BEAT0.
  - BEAT0 goes to BEAT1 if split, else to RESP.
  - BEAT1 goes to RESP.
  - RESP goes to IDLE.
- Handshake:
  - req_ready_o is high only in IDLE.
  - req_valid_i in any other state is ignored.
  - Request inputs need only be valid at the accept edge.
- Lane math:
  - off = addr[1:0]; nbytes = 1/2/4.
  - m8 = ((1<<nbytes)-1) << off (8 bits). Beat0 mask = m8[3:0], beat1 mask = m8[7:4].
  - split = |m8[7:4].
  - w64 = zero-extended wdata << (8*off). Beat0 data = w64[31:0], beat1 data = w64[63:32].
  - Beat0 address = {addr[31:2],2'b00}. Beat1 address = beat0 + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Write beat:
  - One cycle with mem_en_o=1, address, data and mask (mask nonzero) driven.
- Read beat:
  - mem_en_o=1, mask=0000, address held for MEM_LATENCY+1 cycles.
  - mem_rdata_i is sampled at the posedge that ends the last cycle of the beat.
- Outside BEAT states: mem_en_o, mem_wr_mask_o, mem_addr_o and mem_wdata_o are 0.
- Read merge:
  - r64 = {rd1, rd0}, with rd1 = 0 if not split.
  - r = r64 >> (8*off), keep the low nbytes bytes.
  - Extend from bit 8*nbytes-1 (sign or zero per req_unsigned_i); word loads are not extended.
- RESP:
  - resp_valid_o=1 for exactly one cycle.
  - resp_rdata_o is updated on entry to RESP and holds until the next response.
- Latency (cycle 1 = first cycle after the accept edge; L = MEM_LATENCY):
  - Aligned write: RESP in cycle 2.
  - Split write: RESP in cycle 3.
  - Aligned read: RESP in cycle L+2.
  - Split read: RESP in cycle 2L+3.
  - Next accept is possible in the cycle after RESP.

Test Plan:
- Setup for all read scenarios: RAM words [0x100]=0xDDCCBBAA, [0x104]=0x44332211; MEM_LATENCY=1.
- LW 0x100 -> mem_en_o high cycles 1-2, addr 0x100, mask 0000; resp_valid_o cycle 3, rdata 0xDDCCBBAA; ready back cycle 4.
- LB 0x103 signed -> 0xFFFFFFDD; LBU 0x103 -> 0x000000DD; LH 0x102 -> 0xFFFFDDCC; LHU 0x101 -> 0x0000CCBB.
- LW 0x102 (split) -> beat 0x100 (cycles 1-2) then 0x104 (cycles 3-4); resp cycle 5, rdata 0x2211DDCC.
- SH 0x103, wdata 0x0000BEEF -> cycle 1: addr 0x100, mask 1000, data 0xEF000000; cycle 2: addr 0x104, mask 0001, data 0x000000BE; resp cycle 3, rdata 0.
- LW 0xFFFFFFFE -> beat addresses 0xFFFFFFFC then 0x00000000.
- Reset during BEAT1 of the split LW 0x102 -> mem_en_o drops immediately and no resp_valid_o is produced. Then req_valid_i held high through busy cycles of a new request -> only one accept; the next request completes normally.
